// File: rtl/btn_event_gen.sv
// rtl/btn_event_gen.sv - turns a debounced button level into press/step/long/release/short events
// All event timing counts from the press via a ms prescaler that restarts on every press.
module btn_event_gen #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int LONG_PRESS_MS   = 1000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_db,
  output logic press_o,
  output logic step_o,
  output logic long_o,
  output logic release_o,
  output logic short_o,
  output logic held_o
);

  localparam int TICK_CYC = CLK_FREQ_HZ / 1000;
  localparam int HOLD_MAX = (LONG_PRESS_MS > REPEAT_DELAY_MS) ? LONG_PRESS_MS : REPEAT_DELAY_MS;
  localparam int PW       = $clog2(TICK_CYC);
  localparam int HW       = $clog2(HOLD_MAX) + 1;
  localparam int RW       = $clog2(REPEAT_RATE_MS) + 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX);
  localparam logic [HW-1:0] LONG_V   = HW'(LONG_PRESS_MS);
  localparam logic [HW-1:0] DELAY_V  = HW'(REPEAT_DELAY_MS);
  localparam logic [RW-1:0] RATE_V   = RW'(REPEAT_RATE_MS);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  state_e        state_q, state_d;
  logic          btn_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_ms_q, hold_ms_d, hold_inc;
  logic [RW-1:0] rpt_ms_q, rpt_ms_d, rpt_inc;
  logic          long_fired_q, long_fired_d;
  logic          press_q, press_d, step_q, step_d, long_q, long_d;
  logic          release_q, release_d, short_q, short_d, held_q, held_d;
  logic          rise, fall, tick;

  assign rise     = btn_db & ~btn_prev_q;
  assign fall     = ~btn_db & btn_prev_q;
  assign tick     = (state_q != IDLE) && (presc_q == PRE_LAST);
  assign hold_inc = hold_ms_q + 1'b1;
  assign rpt_inc  = rpt_ms_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    hold_ms_d    = hold_ms_q;
    rpt_ms_d     = rpt_ms_q;
    long_fired_d = long_fired_q;
    press_d      = 1'b0;
    step_d       = 1'b0;
    long_d       = 1'b0;
    release_d    = 1'b0;
    short_d      = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (rise) begin
          state_d      = HOLD;
          press_d      = 1'b1;
          step_d       = 1'b1;
          hold_ms_d    = '0;
          rpt_ms_d     = '0;
          long_fired_d = 1'b0;
        end
      end
      HOLD, REPEAT: begin
        // A release in a tick cycle suppresses that tick's step/long and counter updates.
        if (fall) begin
          state_d   = IDLE;
          presc_d   = '0;
          release_d = 1'b1;
          short_d   = ~long_fired_q;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (hold_ms_q != HOLD_SAT) hold_ms_d = hold_inc;
            if (hold_inc == LONG_V && !long_fired_q) begin
              long_d       = 1'b1;
              long_fired_d = 1'b1;
            end
            if (state_q == HOLD) begin
              if (hold_inc == DELAY_V) begin
                state_d  = REPEAT;
                step_d   = 1'b1;
                rpt_ms_d = '0;
              end
            end else if (rpt_inc == RATE_V) begin
              step_d   = 1'b1;
              rpt_ms_d = '0;
            end else begin
              rpt_ms_d = rpt_inc;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      btn_prev_q   <= 1'b0;
      presc_q      <= '0;
      hold_ms_q    <= '0;
      rpt_ms_q     <= '0;
      long_fired_q <= 1'b0;
      press_q      <= 1'b0;
      step_q       <= 1'b0;
      long_q       <= 1'b0;
      release_q    <= 1'b0;
      short_q      <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_prev_q   <= btn_db;
      presc_q      <= presc_d;
      hold_ms_q    <= hold_ms_d;
      rpt_ms_q     <= rpt_ms_d;
      long_fired_q <= long_fired_d;
      press_q      <= press_d;
      step_q       <= step_d;
      long_q       <= long_d;
      release_q    <= release_d;
      short_q      <= short_d;
      held_q       <= held_d;
    end
  end

  assign press_o   = press_q;
  assign step_o    = step_q;
  assign long_o    = long_q;
  assign release_o = release_q;
  assign short_o   = short_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// tb/tb_btn_event_gen.sv - directed bench for btn_event_gen (TICK_CYC=4, long=10, delay=5, rate=2)
module tb_btn_event_gen;

  logic clk = 1'b0;
  logic rst;
  logic btn_db;
  logic press_o, step_o, long_o, release_o, short_o, held_o;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  btn_event_gen #(
    .CLK_FREQ_HZ(4000),
    .LONG_PRESS_MS(10),
    .REPEAT_DELAY_MS(5),
    .REPEAT_RATE_MS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_db(btn_db),
    .press_o(press_o),
    .step_o(step_o),
    .long_o(long_o),
    .release_o(release_o),
    .short_o(short_o),
    .held_o(held_o)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int k);
    chk({tag, ".press"},   k, press_o,   1'b0);
    chk({tag, ".step"},    k, step_o,    1'b0);
    chk({tag, ".long"},    k, long_o,    1'b0);
    chk({tag, ".release"}, k, release_o, 1'b0);
    chk({tag, ".short"},   k, short_o,   1'b0);
    chk({tag, ".held"},    k, held_o,    1'b0);
  endtask

  // Expected outputs k cycles after the press pulse for a hold of h cycles:
  // steps at 0,20,28,36,...; long at 40; release at h; short when h <= 40.
  task automatic chk_hold(input string tag, input int k, input int h);
    logic e_step;
    e_step = (k == 0) || (k < h && k >= 20 && ((k - 20) % 8) == 0);
    chk({tag, ".press"},   k, press_o,   k == 0);
    chk({tag, ".step"},    k, step_o,    e_step);
    chk({tag, ".long"},    k, long_o,    k == 40 && k < h);
    chk({tag, ".release"}, k, release_o, k == h);
    chk({tag, ".short"},   k, short_o,   k == h && h <= 40);
    chk({tag, ".held"},    k, held_o,    k < h);
  endtask

  // Button sampled high for h edges; checks cycles P..P+h+1 and returns in cycle P+h+1.
  task automatic run_hold(input string tag, input int h);
    rst    = 1'b0;
    btn_db = 1'b1;
    step_clk();
    for (int k = 0; k <= h + 1; k++) begin
      chk_hold(tag, k, h);
      if (k == h - 1) btn_db = 1'b0;
      if (k < h + 1) step_clk();
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk_zero(tag, k);
      step_clk();
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_db = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_clk();
      chk_zero("reset_held", k);
    end
    run_hold("after_reset", 12);
    idle("gap1", 4);

    run_hold("short", 12);
    idle("gap2", 3);

    run_hold("long", 60);
    idle("gap3", 3);

    run_hold("rel_on_tick", 28);
    idle("gap4", 3);

    btn_db = 1'b1;
    step_clk();
    for (int k = 0; k <= 25; k++) begin
      chk_hold("mid_rst", k, 100);
      if (k == 25) rst = 1'b1;
      step_clk();
    end
    chk_zero("mid_rst_on", 26);
    step_clk();
    chk_zero("mid_rst_on", 27);
    run_hold("after_mid_rst", 24);
    idle("gap5", 3);

    run_hold("b2b_long", 45);
    run_hold("b2b_quick", 6);
    idle("gap6", 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
